mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Initiator side of the data-memory interface. Sits in the M stage and turns a load/store
//   (width, sign, address, store data) into a word-aligned bus transaction with byte enables.
//   Handles variable-latency valid/ready handshake, stalls the pipeline while busy, extracts and
//   extends load data, flags misaligned accesses, and times out unanswered requests.
// PARAMETERS
//   TIMEOUT_CYCLES  default 16  max cycles bus_valid stays high without bus_ready before BusErr
//   CNT_W           default 5   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//   Clk        in   1   clock, all state updates on posedge
//   Reset      in   1   synchronous, active-high
//   Req        in   1   M-stage memory op present this cycle
//   We         in   1   1 = store, 0 = load
//   OpWidth    in   2   00 word, 01 half, 10 byte, 11 illegal
//   LoadSigned in   1   1 = sign-extend half/byte loads, 0 = zero-extend
//   Addr       in   32  byte address
//   WData      in   32  store data, right-aligned
//   PC         in   32  PC of the op, used only for trace
//   Stall      out  1   freeze upstream stages
//   Done       out  1   one-cycle pulse: op completed, RData valid (loads)
//   RData      out  32  extracted/extended load data
//   AdEL       out  1   one-cycle pulse: misaligned/illegal load
//   AdES       out  1   one-cycle pulse: misaligned/illegal store
//   BusErr     out  1   one-cycle pulse with Done when a request times out
//   bus_valid  out  1   request valid; held until bus_ready
//   bus_we     out  1   request is a write
//   bus_addr   out  32  {Addr[31:2],2'b00}
//   bus_be     out  4   byte enables
//   bus_wdata  out  32  lane-replicated store data
//   bus_ready  in   1   responder accepts; for reads bus_rdata valid in same cycle
//   bus_rdata  in   32  read word
// BEHAVIOUR
//   Reset: state IDLE; Stall, Done, AdEL, AdES, BusErr, bus_valid, bus_we = 0; RData, bus_be,
//     bus_addr, bus_wdata = 0; counter = 0. Reset mid-transaction drops bus_valid next edge.
//   Misalign: word Addr[1:0]!=0; half Addr[0]!=0; OpWidth==11 always.
//   FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: Stall = Req & aligned (combinational). Req & aligned: latch We/OpWidth/LoadSigned/
//     Addr[1:0]/bus fields, go BUSY. Req & misaligned: pulse AdEL (We=0) or AdES (We=1) next
//     cycle, no bus activity, stay IDLE, Stall=0.
//   BUSY: bus_valid=1, Stall=1, fields stable. bus_ready: capture bus_rdata, go DONE, counter=0.
//     Else counter++; counter==TIMEOUT_CYCLES-1 without ready: go DONE with BusErr, RData=0.
//   DONE: bus_valid=0, Done=1, Stall=0, RData valid; next cycle IDLE. Req in DONE not accepted
//     (upstream still holds it; accepted next cycle in IDLE).
//   Min latency: Req at cycle 0, valid at 1, ready at 1 -> Done at 2. Stall high cycles 0..1.
//   bus_be: word 1111; half Addr[1]?1100:0011; byte 4'b0001<<Addr[1:0]. bus_we=We.
//   bus_wdata: word WData; half {2{WData[15:0]}}; byte {4{WData[7:0]}}.
//   RData: word = rdata; half = rdata lane Addr[1] (16b); byte = lane Addr[1:0] (8b); upper
//     bits = LoadSigned ? copies of lane MSB : 0. Stores leave RData unchanged.
// CONFIGURATION
//   MEM_TRACE_EN defined: on the accepting edge of a store (BUSY & bus_ready & bus_we)
//     $display("%d@%h: *%h <= %h", $time, PC_latched, bus_addr, bus_wdata) plus be in hex.
//   Undefined: no $display, no extra logic; identical port behaviour.
// TESTING
//   Store word 0x12345678 @0x10, ready same cycle -> be=1111, addr 0x10, Done at cycle 2.
//   Store byte 0xAB @0x13 -> be=1000, wdata=0xABABABAB; half load @0x12 signed, rdata
//     0xABCD0000 -> RData=0xFFFFABCD; unsigned -> 0x0000ABCD.
//   Load half @0x11 -> AdEL pulse, bus_valid never rises, Stall=0; OpWidth=11 store -> AdES.
//   Ready delayed 5 cycles -> Stall high throughout, bus_addr/be stable, Done 1 cycle after ready.
//   No ready for TIMEOUT_CYCLES -> BusErr+Done pulse, RData=0; Reset asserted in BUSY ->
//     bus_valid=0, state IDLE next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// M-stage data-memory initiator: load/store to word-aligned valid/ready bus with byte enables.
// Optional store trace via `define MEM_TRACE_EN (default build: no trace, no extra logic).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        We,
    input  logic [1:0]  OpWidth,
    input  logic        LoadSigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [31:0] PC,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] RData,
    output logic        AdEL,
    output logic        AdES,
    output logic        BusErr,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        width_q, width_d;
    logic              signed_q, signed_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic              buserr_q, buserr_d;

    logic              misalign;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [15:0]       half_lane;
    logic [7:0]        byte_lane;
    logic [31:0]       load_ext;

    // Illegal width counts as misaligned so it takes the same exception path.
    always_comb begin
        misalign = 1'b0;
        case (OpWidth)
            2'b00:   misalign = (Addr[1:0] != 2'b00);
            2'b01:   misalign = Addr[0];
            2'b10:   misalign = 1'b0;
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WData;
        case (OpWidth)
            2'b01: begin
                be_new    = Addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{WData[15:0]}};
            end
            2'b10: begin
                be_new    = 4'b0001 << Addr[1:0];
                wdata_new = {4{WData[7:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = WData;
            end
        endcase
    end

    always_comb begin
        half_lane = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        byte_lane = bus_rdata[7:0];
        case (lo_q)
            2'd1:    byte_lane = bus_rdata[15:8];
            2'd2:    byte_lane = bus_rdata[23:16];
            2'd3:    byte_lane = bus_rdata[31:24];
            default: byte_lane = bus_rdata[7:0];
        endcase
        case (width_q)
            2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
            2'b10:   load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        width_d  = width_q;
        signed_d = signed_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        adel_d   = 1'b0;
        ades_d   = 1'b0;
        buserr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    if (misalign) begin
                        adel_d = ~We;
                        ades_d = We;
                    end else begin
                        we_d     = We;
                        width_d  = OpWidth;
                        signed_d = LoadSigned;
                        lo_d     = Addr[1:0];
                        addr_d   = {Addr[31:2], 2'b00};
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // A ready arriving on the last counted cycle still wins over the timeout.
                if (bus_ready) begin
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    buserr_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            width_q  <= 2'b00;
            signed_q <= 1'b0;
            lo_q     <= 2'b00;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            width_q  <= width_d;
            signed_q <= signed_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            adel_q   <= adel_d;
            ades_q   <= ades_d;
            buserr_q <= buserr_d;
        end
    end

    always_comb begin
        Stall     = 1'b0;
        bus_valid = 1'b0;
        Done      = 1'b0;
        case (state_q)
            S_IDLE:  Stall = Req & ~misalign;
            S_BUSY: begin
                Stall     = 1'b1;
                bus_valid = 1'b1;
            end
            S_DONE:  Done = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    assign RData     = rdata_q;
    assign AdEL      = adel_q;
    assign AdES      = ades_q;
    assign BusErr    = buserr_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= '0;
        end else if (state_q == S_IDLE && Req && !misalign) begin
            pc_q <= PC;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && state_q == S_BUSY && bus_ready && we_q) begin
            $display("%d@%h: *%h <= %h be=%h", $time, pc_q, addr_q, wdata_q, be_q);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int T = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req, We, LoadSigned;
    logic [1:0]  OpWidth;
    logic [31:0] Addr, WData, PC;
    logic        Stall, Done, AdEL, AdES, BusErr;
    logic [31:0] RData;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rd  = '0;

    mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .OpWidth(OpWidth),
        .LoadSigned(LoadSigned), .Addr(Addr), .WData(WData), .PC(PC),
        .Stall(Stall), .Done(Done), .RData(RData), .AdEL(AdEL), .AdES(AdES),
        .BusErr(BusErr), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered just after a posedge with the DUT idle; leaves the same way.
    task automatic run_op(input logic we, input logic [1:0] w, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int delay);
        logic [31:0] nb, ebe, ewd, lane, erd, ealign;
        bit          mis, tmo;
        int          n;
        nb  = (w == 2'd0) ? 32'd4 : (w == 2'd1) ? 32'd2 : 32'd1;
        mis = (w == 2'd3) || ((addr % nb) != 0);
        Req = 1'b1; We = we; OpWidth = w; LoadSigned = sg; Addr = addr; WData = wd;
        PC = $urandom; bus_ready = 1'b0;
        @(negedge Clk);
        chk("stall_req", {31'd0, Stall}, {31'd0, !mis});
        chk("valid_idle", {31'd0, bus_valid}, 32'd0);
        @(posedge Clk); #1;
        // Scramble request inputs: the DUT must hold its latched copy.
        Req = 1'b0; We = $urandom; OpWidth = 2'($urandom); LoadSigned = $urandom;
        Addr = $urandom; WData = $urandom;
        if (mis) begin
            @(negedge Clk);
            chk("adel", {31'd0, AdEL}, {31'd0, !we});
            chk("ades", {31'd0, AdES}, {31'd0, we});
            chk("mis_valid", {31'd0, bus_valid}, 32'd0);
            chk("mis_stall", {31'd0, Stall}, 32'd0);
            chk("mis_done", {31'd0, Done}, 32'd0);
            @(posedge Clk); #1;
            @(negedge Clk);
            chk("adel_pulse", {31'd0, AdEL}, 32'd0);
            chk("ades_pulse", {31'd0, AdES}, 32'd0);
            chk("mis_valid2", {31'd0, bus_valid}, 32'd0);
            chk("mis_rdata", RData, exp_rd);
        end else begin
            ebe    = ((32'd1 << nb) - 1) << (addr % 4);
            ewd    = (nb == 4) ? wd : (nb == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001
                                                : {24'd0, wd[7:0]} * 32'h0101_0101;
            ealign = addr - (addr % 4);
            tmo    = (delay >= T);
            n      = tmo ? T : delay + 1;
            for (int k = 0; k < n; k++) begin
                bus_ready = (k == delay);
                bus_rdata = (k == delay) ? rd : $urandom;
                @(negedge Clk);
                chk("busy_valid", {31'd0, bus_valid}, 32'd1);
                chk("busy_stall", {31'd0, Stall}, 32'd1);
                chk("busy_done", {31'd0, Done}, 32'd0);
                chk("bus_addr", bus_addr, ealign);
                chk("bus_be", {28'd0, bus_be}, ebe);
                chk("bus_wdata", bus_wdata, ewd);
                chk("bus_we", {31'd0, bus_we}, {31'd0, we});
                @(posedge Clk); #1;
                bus_ready = 1'b0;
            end
            if (tmo) begin
                erd = 32'd0;
            end else if (we) begin
                erd = exp_rd;
            end else begin
                lane = rd >> (8 * (addr % 4));
                if (nb == 4) begin
                    erd = rd;
                end else if (nb == 2) begin
                    erd = lane % 65536;
                    if (sg && lane[15]) erd = erd + 32'hFFFF_0000;
                end else begin
                    erd = lane % 256;
                    if (sg && lane[7]) erd = erd + 32'hFFFF_FF00;
                end
            end
            exp_rd = erd;
            @(negedge Clk);
            chk("done", {31'd0, Done}, 32'd1);
            chk("buserr", {31'd0, BusErr}, {31'd0, tmo});
            chk("done_stall", {31'd0, Stall}, 32'd0);
            chk("done_valid", {31'd0, bus_valid}, 32'd0);
            chk("rdata", RData, erd);
            @(posedge Clk); #1;
            @(negedge Clk);
            chk("done_pulse", {31'd0, Done}, 32'd0);
            chk("buserr_pulse", {31'd0, BusErr}, 32'd0);
            chk("idle_valid", {31'd0, bus_valid}, 32'd0);
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] w;
        int         d;
        Reset = 1'b1; Req = 1'b0; We = 1'b0; OpWidth = 2'd0; LoadSigned = 1'b0;
        Addr = '0; WData = '0; PC = '0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", RData, 32'd0);
        chk("rst_exc", {29'd0, AdEL, AdES, BusErr}, 32'd0);
        @(posedge Clk); #1;

        run_op(1'b1, 2'd0, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 0);
        run_op(1'b1, 2'd2, 1'b0, 32'h13, 32'h0000_00AB, 32'h0, 1);
        run_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hABCD_0000, 0);
        run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hABCD_0000, 2);
        run_op(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 0);
        run_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 0);
        run_op(1'b0, 2'd2, 1'b1, 32'h41, 32'h0, 32'h1234_8056, 5);
        run_op(1'b0, 2'd0, 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, T - 1);
        run_op(1'b0, 2'd0, 1'b0, 32'h48, 32'h0, 32'hCAFE_F00D, T + 3);
        run_op(1'b1, 2'd1, 1'b0, 32'h4E, 32'h0000_9876, 32'h0, T);

        // Reset while a request is outstanding.
        Req = 1'b1; We = 1'b0; OpWidth = 2'd0; Addr = 32'h80; bus_ready = 1'b0;
        @(posedge Clk); #1 Req = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("pre_rst_valid", {31'd0, bus_valid}, 32'd1);
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("midrst_valid", {31'd0, bus_valid}, 32'd0);
        chk("midrst_stall", {31'd0, Stall}, 32'd0);
        chk("midrst_done", {31'd0, Done}, 32'd0);
        chk("midrst_be", {28'd0, bus_be}, 32'd0);
        chk("midrst_rdata", RData, 32'd0);
        exp_rd = 32'd0;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("midrst_idle_done", {31'd0, Done}, 32'd0);
        @(posedge Clk); #1;

        for (int i = 0; i < 150; i++) begin
            w = 2'($urandom_range(0, 3));
            if (w == 2'd3 && $urandom_range(0, 3) != 0) w = 2'd0;
            d = ($urandom_range(0, 15) == 0) ? T + int'($urandom_range(0, 2))
                                             : int'($urandom_range(0, 6));
            run_op($urandom, w, $urandom, $urandom, $urandom, $urandom, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
